// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled majority-vote bit recovery, parity/framing checks,
// break detection and a single-entry valid/ready output buffer with overrun reporting.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 break_det
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW      = $clog2(OVERSAMPLE);
    localparam int BW      = $clog2(DATA_BITS + 1);

    localparam logic [DW-1:0] DIV_MAX   = DW'(DIV - 1);
    localparam logic [TW-1:0] TC_S0     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TC_S1     = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TC_S2     = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] TC_MAX    = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } state_t;

    state_t                 r_state;
    logic [1:0]             r_sync;
    logic [DW-1:0]          r_divCnt;
    logic [TW-1:0]          r_tc;
    logic                   r_s0;
    logic                   r_s1;
    logic [DATA_BITS-1:0]   r_shift;
    logic [BW-1:0]          r_bitCnt;
    logic                   r_parBit;
    logic                   r_stopCnt;
    logic                   r_ferr;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_valid;
    logic                   r_perrOut;
    logic                   r_ferrOut;
    logic                   r_ovr;
    logic                   r_brk;

    logic w_rx;
    logic w_tick;
    logic w_resolve;
    logic w_wrap;
    logic w_maj;
    logic w_allZero;
    logic w_parXor;
    logic w_perr;
    logic w_isBreak;
    logic w_commit;

    // The line is asynchronous; the synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) r_sync <= 2'b11;
        else     r_sync <= {r_sync[0], uart_rx};
    end

    assign w_rx      = r_sync[1];
    assign w_tick    = (r_divCnt == DIV_MAX);
    assign w_resolve = w_tick && (r_tc == TC_S2);
    assign w_wrap    = w_tick && (r_tc == TC_MAX);
    assign w_maj     = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
    assign w_allZero = (r_shift == '0) && ((PARITY == 0) || !r_parBit);
    assign w_parXor  = (^r_shift) ^ r_parBit;
    assign w_perr    = (PARITY == 1) ? ~w_parXor : (PARITY == 2) ? w_parXor : 1'b0;
    assign w_isBreak = (r_state == STOP) && w_resolve && (r_stopCnt == 1'b0) && !w_maj && w_allZero;
    assign w_commit  = (r_state == STOP) && w_resolve && (r_stopCnt == STOP_LAST) && !w_isBreak;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_divCnt  <= '0;
            r_tc      <= '0;
            r_s0      <= 1'b1;
            r_s1      <= 1'b1;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_parBit  <= 1'b0;
            r_stopCnt <= 1'b0;
            r_ferr    <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perrOut <= 1'b0;
            r_ferrOut <= 1'b0;
            r_ovr     <= 1'b0;
            r_brk     <= 1'b0;
        end else begin
            r_ovr <= 1'b0;
            r_brk <= 1'b0;
            if (r_valid && rx_ready) r_valid <= 1'b0;

            r_divCnt <= w_tick ? '0 : r_divCnt + 1'b1;
            if (w_tick) r_tc <= (r_tc == TC_MAX) ? '0 : r_tc + 1'b1;
            if (w_tick && (r_tc == TC_S0)) r_s0 <= w_rx;
            if (w_tick && (r_tc == TC_S1)) r_s1 <= w_rx;

            case (r_state)
                IDLE: begin
                    if (!w_rx) begin
                        r_state  <= START;
                        r_tc     <= '0;
                        r_divCnt <= '0;
                    end
                end
                START: begin
                    if (w_resolve && w_maj) begin
                        r_state <= IDLE;
                    end else if (w_wrap) begin
                        r_state  <= DATA;
                        r_bitCnt <= '0;
                    end
                end
                DATA: begin
                    if (w_resolve) begin
                        r_shift  <= {w_maj, r_shift[DATA_BITS-1:1]};
                        r_bitCnt <= r_bitCnt + 1'b1;
                    end
                    if (w_wrap && (r_bitCnt == BIT_LAST)) begin
                        r_state   <= (PARITY != 0) ? PAR : STOP;
                        r_ferr    <= 1'b0;
                        r_stopCnt <= 1'b0;
                    end
                end
                PAR: begin
                    if (w_resolve) r_parBit <= w_maj;
                    if (w_wrap)    r_state  <= STOP;
                end
                STOP: begin
                    // Leave at the last stop bit's resolve point so the next start edge is caught early.
                    if (w_isBreak) begin
                        r_brk   <= 1'b1;
                        r_state <= BRK;
                    end else if (w_commit) begin
                        r_state <= IDLE;
                    end else if (w_resolve) begin
                        r_ferr    <= r_ferr | ~w_maj;
                        r_stopCnt <= 1'b1;
                    end
                end
                BRK: begin
                    if (w_rx) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_commit) begin
                if (!r_valid || rx_ready) begin
                    r_data    <= r_shift;
                    r_perrOut <= w_perr;
                    r_ferrOut <= r_ferr | ~w_maj;
                    r_valid   <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign parity_err  = r_perrOut;
    assign frame_err   = r_ferrOut;
    assign overrun_err = r_ovr;
    assign break_det   = r_brk;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance driven with directed and random
// frames; a frame-level model predicts delivered words, break pulses and overruns.
module tb_uart_rx_cfg;
    localparam int CLKF = 3_200_000;
    localparam int BAUD = 100_000;
    localparam int BIT  = 32;

    logic clk = 1'b0;
    logic rst;
    logic lineA, lineB;
    logic readyA, readyB;
    logic [7:0] dataA;
    logic [6:0] dataB;
    logic validA, perrA, ferrA, ovrA, brkA;
    logic validB, perrB, ferrB, ovrB, brkB;

    int vectorCount = 0;
    int missCount   = 0;
    int readyModeA  = 1;
    int readyModeB  = 1;
    int brkCnt[2]   = '{0, 0};
    int ovrCnt[2]   = '{0, 0};
    int expBrk[2]   = '{0, 0};
    int expOvr[2]   = '{0, 0};
    logic [10:0] qA[$];
    logic [10:0] qB[$];

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16)
    ) dutA (
        .clk(clk), .rst(rst), .uart_rx(lineA), .rx_data(dataA), .rx_valid(validA), .rx_ready(readyA),
        .parity_err(perrA), .frame_err(ferrA), .overrun_err(ovrA), .break_det(brkA)
    );

    uart_rx_cfg #(
        .CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(16)
    ) dutB (
        .clk(clk), .rst(rst), .uart_rx(lineB), .rx_data(dataB), .rx_valid(validB), .rx_ready(readyB),
        .parity_err(perrB), .frame_err(ferrB), .overrun_err(ovrB), .break_det(brkB)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Ready generators: 0 = hold low, 1 = hold high, 2 = random per cycle.
    initial begin
        readyA = 1'b0;
        forever begin
            @(posedge clk); #1;
            readyA = (readyModeA == 2) ? 1'($urandom_range(0, 1)) : (readyModeA == 1);
        end
    end

    initial begin
        readyB = 1'b0;
        forever begin
            @(posedge clk); #1;
            readyB = (readyModeB == 2) ? 1'($urandom_range(0, 1)) : (readyModeB == 1);
        end
    end

    // Each accepted word must be the oldest predicted one.
    always @(negedge clk) begin : monitor
        logic [10:0] e;
        if (!rst) begin
            if (validA && readyA) begin
                if (qA.size() == 0) checkOutput("A unexpected word", {21'd0, perrA, ferrA, 1'b0, dataA}, 32'h7ff);
                else begin
                    e = qA.pop_front();
                    checkOutput("A word {perr,ferr,data}", {21'd0, perrA, ferrA, 1'b0, dataA}, {21'd0, e});
                end
            end
            if (validB && readyB) begin
                if (qB.size() == 0) checkOutput("B unexpected word", {21'd0, perrB, ferrB, 2'b0, dataB}, 32'h7ff);
                else begin
                    e = qB.pop_front();
                    checkOutput("B word {perr,ferr,data}", {21'd0, perrB, ferrB, 2'b0, dataB}, {21'd0, e});
                end
            end
            if (brkA) brkCnt[0]++;
            if (brkB) brkCnt[1]++;
            if (ovrA) ovrCnt[0]++;
            if (ovrB) ovrCnt[1]++;
        end
    end

    task automatic setLine(input int sel, input logic v);
        if (sel == 0) lineA = v;
        else          lineB = v;
    endtask

    task automatic sendBit(input int sel, input logic v);
        setLine(sel, v);
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic idleBits(input int sel, input int n);
        for (int i = 0; i < n; i++) sendBit(sel, 1'b1);
    endtask

    // Sends one frame and predicts its outcome: sel 0 = 8N1, sel 1 = 7 data, even parity, 2 stop.
    task automatic applyStimulus(input int sel, input logic [8:0] data, input logic parFlip,
                                 input logic stop1, input logic stop2, input logic dropIt);
        int nb;
        logic [8:0] dm;
        logic par, perr, ferr, isBreak;
        nb      = (sel == 0) ? 8 : 7;
        dm      = (sel == 0) ? {1'b0, data[7:0]} : {2'b0, data[6:0]};
        par     = (^dm) ^ parFlip;
        perr    = (sel == 1) ? ((^dm) ^ par) : 1'b0;
        ferr    = !stop1 || ((sel == 1) && !stop2);
        isBreak = (dm == 9'd0) && ((sel == 0) || !par) && !stop1;
        if (isBreak)       expBrk[sel]++;
        else if (dropIt)   expOvr[sel]++;
        else if (sel == 0) qA.push_back({perr, ferr, dm});
        else               qB.push_back({perr, ferr, dm});
        sendBit(sel, 1'b0);
        for (int i = 0; i < nb; i++) sendBit(sel, dm[i]);
        if (sel == 1) sendBit(sel, par);
        sendBit(sel, stop1);
        if (sel == 1) sendBit(sel, stop2);
        idleBits(sel, 2);
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, " A valid"}, {31'd0, validA}, 32'd0);
        checkOutput({tag, " A data"}, {24'd0, dataA}, 32'd0);
        checkOutput({tag, " A perr"}, {31'd0, perrA}, 32'd0);
        checkOutput({tag, " A ferr"}, {31'd0, ferrA}, 32'd0);
        checkOutput({tag, " A overrun"}, {31'd0, ovrA}, 32'd0);
        checkOutput({tag, " A break"}, {31'd0, brkA}, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        lineA = 1'b1;
        lineB = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkResetA("reset");
        checkOutput("reset B valid", {31'd0, validB}, 32'd0);
        checkOutput("reset B data", {25'd0, dataB}, 32'd0);
        checkOutput("reset B flags", {28'd0, perrB, ferrB, ovrB, brkB}, 32'd0);
        rst = 1'b0;
        idleBits(0, 2);

        applyStimulus(0, 9'h0A5, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("A 0xA5 delivered", qA.size(), 32'd0);

        // Random 8N1 traffic with a randomly stalling consumer, occasional zero data and bad stop bits.
        readyModeA = 2;
        for (int n = 0; n < 60; n++) begin
            logic [8:0] d;
            d = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(0, 255));
            applyStimulus(0, d, 1'b0, ($urandom_range(0, 7) != 0), 1'b1, 1'b0);
            idleBits(0, $urandom_range(0, 2));
        end
        readyModeA = 1;
        idleBits(0, 1);
        checkOutput("A random drained", qA.size(), 32'd0);

        applyStimulus(1, 9'h041, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1, 9'h041, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1, 9'h041, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("B directed drained", qB.size(), 32'd0);

        readyModeB = 2;
        for (int n = 0; n < 40; n++) begin
            logic [8:0] d;
            d = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(0, 127));
            applyStimulus(1, d, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 7) != 0), 1'b0);
            idleBits(1, $urandom_range(0, 2));
        end
        readyModeB = 1;
        idleBits(1, 1);
        checkOutput("B random drained", qB.size(), 32'd0);

        // Glitch shorter than half a bit must be rejected as a false start.
        setLine(0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        idleBits(0, 3);
        checkOutput("glitch A valid", {31'd0, validA}, 32'd0);
        checkOutput("glitch A breaks", brkCnt[0], expBrk[0]);
        applyStimulus(0, 9'h03C, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("A 0x3C delivered", qA.size(), 32'd0);

        readyModeA = 0;
        applyStimulus(0, 9'h011, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(0, 9'h022, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("overrun A held data", {24'd0, dataA}, 32'h11);
        checkOutput("overrun A valid held", {31'd0, validA}, 32'd1);
        checkOutput("overrun A pulses", ovrCnt[0], expOvr[0]);
        readyModeA = 1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("overrun A valid after accept", {31'd0, validA}, 32'd0);
        checkOutput("overrun A drained", qA.size(), 32'd0);

        setLine(0, 1'b0);
        repeat (12 * BIT) @(posedge clk);
        #1;
        expBrk[0]++;
        idleBits(0, 2);
        checkOutput("break A pulses", brkCnt[0], expBrk[0]);
        checkOutput("break A valid", {31'd0, validA}, 32'd0);
        applyStimulus(0, 9'h05A, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("A 0x5A delivered", qA.size(), 32'd0);

        // Abort a 0xC3 frame during data bit 4 with a two-cycle reset.
        sendBit(0, 1'b0);
        sendBit(0, 1'b1);
        sendBit(0, 1'b1);
        sendBit(0, 1'b0);
        sendBit(0, 1'b0);
        setLine(0, 1'b0);
        repeat (BIT / 2) @(posedge clk);
        #1;
        rst   = 1'b1;
        lineA = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetA("mid-frame reset");
        idleBits(0, 2);
        checkOutput("mid-frame reset A no word", {31'd0, validA}, 32'd0);
        applyStimulus(0, 9'h0C3, 1'b0, 1'b1, 1'b1, 1'b0);

        idleBits(0, 2);
        checkOutput("final A queue", qA.size(), 32'd0);
        checkOutput("final B queue", qB.size(), 32'd0);
        checkOutput("final A breaks", brkCnt[0], expBrk[0]);
        checkOutput("final B breaks", brkCnt[1], expBrk[1]);
        checkOutput("final A overruns", ovrCnt[0], expOvr[0]);
        checkOutput("final B overruns", ovrCnt[1], expOvr[1]);
        checkOutput("final valids", {30'd0, validA, validB}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
